// File: rtl/brisc_pkg.sv
// rtl/brisc_pkg.sv - shared widths, memory timing and arbiter types
//
// Purpose: common definitions for the memory subsystem. Line and address
// widths, the main-memory load response delay, and the enumerations used by
// the memory arbiter for its FSM state and client identity.
// Ports: none (package).

package brisc_pkg;

  localparam int ADDRESS_WIDTH    = 32;
  localparam int CACHE_LINE_WIDTH = 128;
  localparam int MEM_RESP_DELAY   = 5;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_LD,
    ARB_WAIT_ST
  } arb_state_e;

  typedef enum logic {
    ARB_ICACHE,
    ARB_DCACHE
  } arb_client_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client (I-cache / D-cache) main memory arbiter
//
// Purpose: merges I-cache line reads and D-cache line reads/evictions onto the
// single main-memory request port, one transaction in flight at a time, and
// routes the returned line back to the client that owns the transaction.
// Loads complete when memory returns mem_fill; stores are never acknowledged
// by memory, so completion is timed locally with a STORE_LAT countdown.
//
// Configuration: define MEM_ARB_RR_EN for round-robin arbitration between the
// two clients; otherwise the D-cache has fixed priority.
//
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   icache_req/addr           I-cache line read request (level) and address
//   icache_fill/_data/_addr   1-cycle return pulse with line and address
//   dcache_req/_req_store     D-cache request (level), 1 = evict, 0 = read
//   dcache_addr/_evict_data   D-cache line address and line to write
//   dcache_fill/_data/_addr   1-cycle completion pulse (data 0 for stores)
//   mem_req/_req_store        registered 1-cycle request pulse and store flag
//   mem_req_address/_evict_data registered request address/line, held to next grant
//   mem_fill/_data/_address   load return from memory

module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_RESP_DELAY,
  parameter int STORE_LAT   = MEM_LATENCY + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        icache_req,
  input  logic [ADDRESS_WIDTH-1:0]    icache_addr,
  output logic                        icache_fill,
  output logic [CACHE_LINE_WIDTH-1:0] icache_fill_data,
  output logic [ADDRESS_WIDTH-1:0]    icache_fill_addr,
  input  logic                        dcache_req,
  input  logic                        dcache_req_store,
  input  logic [ADDRESS_WIDTH-1:0]    dcache_addr,
  input  logic [CACHE_LINE_WIDTH-1:0] dcache_evict_data,
  output logic                        dcache_fill,
  output logic [CACHE_LINE_WIDTH-1:0] dcache_fill_data,
  output logic [ADDRESS_WIDTH-1:0]    dcache_fill_addr,
  output logic                        mem_req,
  output logic                        mem_req_store,
  output logic [ADDRESS_WIDTH-1:0]    mem_req_address,
  output logic [CACHE_LINE_WIDTH-1:0] mem_req_evict_data,
  input  logic                        mem_fill,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_fill_data,
  input  logic [ADDRESS_WIDTH-1:0]    mem_fill_address
);

  localparam int CW = $clog2(STORE_LAT + 1);

  arb_state_e  state, state_next;
  arb_client_e owner;
  logic [CW-1:0] st_cnt;
  logic          st_fill_q;   // registered store-completion pulse

  logic dreq;
  logic grant_d;
  logic do_grant;
  logic ld_done;
  logic st_done;

  // The store completion pulse is registered, so the FSM is already IDLE while
  // dcache_fill is high and the D-cache has not yet dropped its request. Mask
  // that stale request so the finished store is not granted a second time; a
  // waiting I-cache request is still served in that cycle.
  assign dreq = dcache_req & ~st_fill_q;

`ifdef MEM_ARB_RR_EN
  arb_client_e rr_last;

  // On conflict, grant the client that was not granted last.
  assign grant_d = dreq & (~icache_req | (rr_last == ARB_ICACHE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= ARB_ICACHE;
    end else if (do_grant) begin
      rr_last <= grant_d ? ARB_DCACHE : ARB_ICACHE;
    end
  end
`else
  assign grant_d = dreq;
`endif

  assign do_grant = (state == ARB_IDLE) & (icache_req | dreq);
  assign ld_done  = (state == ARB_WAIT_LD) & mem_fill;
  assign st_done  = (state == ARB_WAIT_ST) & (st_cnt == CW'(1));

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (do_grant) begin
          state_next = (grant_d && dcache_req_store) ? ARB_WAIT_ST : ARB_WAIT_LD;
        end
      end
      ARB_WAIT_LD: begin
        if (mem_fill) state_next = ARB_IDLE;
      end
      ARB_WAIT_ST: begin
        if (st_cnt == CW'(1)) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ARB_IDLE;
      owner              <= ARB_DCACHE;
      st_cnt             <= '0;
      st_fill_q          <= 1'b0;
      mem_req            <= 1'b0;
      mem_req_store      <= 1'b0;
      mem_req_address    <= '0;
      mem_req_evict_data <= '0;
    end else begin
      state     <= state_next;
      mem_req   <= do_grant;
      st_fill_q <= st_done;
      if (do_grant) begin
        owner              <= grant_d ? ARB_DCACHE : ARB_ICACHE;
        mem_req_store      <= grant_d & dcache_req_store;
        mem_req_address    <= grant_d ? dcache_addr : icache_addr;
        mem_req_evict_data <= (grant_d && dcache_req_store) ? dcache_evict_data : '0;
        st_cnt             <= (grant_d && dcache_req_store) ? CW'(STORE_LAT) : '0;
      end else if (state == ARB_WAIT_ST) begin
        st_cnt <= st_cnt - CW'(1);
      end
    end
  end

  // Load returns are routed combinationally in the cycle memory presents them.
  // Fills arriving in IDLE or WAIT_ST (e.g. in flight across a reset) are ignored.
  always_comb begin
    icache_fill      = ld_done & (owner == ARB_ICACHE);
    icache_fill_data = '0;
    icache_fill_addr = '0;
    dcache_fill      = (ld_done & (owner == ARB_DCACHE)) | st_fill_q;
    dcache_fill_data = '0;
    dcache_fill_addr = '0;
    if (icache_fill) begin
      icache_fill_data = mem_fill_data;
      icache_fill_addr = mem_fill_address;
    end
    if (ld_done && owner == ARB_DCACHE) begin
      dcache_fill_data = mem_fill_data;
      dcache_fill_addr = mem_fill_address;
    end else if (st_fill_q) begin
      // No new grant has happened yet, so the request address is the store's.
      dcache_fill_addr = mem_req_address;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a memory model

`timescale 1ns/1ps

module tb_mem_arbiter;
  import brisc_pkg::*;

  localparam int AW   = ADDRESS_WIDTH;
  localparam int LW   = CACHE_LINE_WIDTH;
  localparam int LAT  = 5;
  localparam int SLAT = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          icache_req = 1'b0;
  logic [AW-1:0] icache_addr = '0;
  logic          icache_fill;
  logic [LW-1:0] icache_fill_data;
  logic [AW-1:0] icache_fill_addr;
  logic          dcache_req = 1'b0;
  logic          dcache_req_store = 1'b0;
  logic [AW-1:0] dcache_addr = '0;
  logic [LW-1:0] dcache_evict_data = '0;
  logic          dcache_fill;
  logic [LW-1:0] dcache_fill_data;
  logic [AW-1:0] dcache_fill_addr;
  logic          mem_req;
  logic          mem_req_store;
  logic [AW-1:0] mem_req_address;
  logic [LW-1:0] mem_req_evict_data;
  logic          mem_fill = 1'b0;
  logic [LW-1:0] mem_fill_data = '0;
  logic [AW-1:0] mem_fill_address = '0;

  mem_arbiter #(.MEM_LATENCY(LAT), .STORE_LAT(SLAT)) dut (
    .clk(clk), .reset(reset),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_fill(icache_fill), .icache_fill_data(icache_fill_data), .icache_fill_addr(icache_fill_addr),
    .dcache_req(dcache_req), .dcache_req_store(dcache_req_store), .dcache_addr(dcache_addr),
    .dcache_evict_data(dcache_evict_data),
    .dcache_fill(dcache_fill), .dcache_fill_data(dcache_fill_data), .dcache_fill_addr(dcache_fill_addr),
    .mem_req(mem_req), .mem_req_store(mem_req_store), .mem_req_address(mem_req_address),
    .mem_req_evict_data(mem_req_evict_data),
    .mem_fill(mem_fill), .mem_fill_data(mem_fill_data), .mem_fill_address(mem_fill_address)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input bit ok, input string name, input string detail);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: %s", name, detail);
    end
  endfunction

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    return {(LW/AW){a ^ 32'h5EED_0000}};
  endfunction

  // ---------------- memory model (responder) ----------------
  logic [LW-1:0] mem_array [64];
  logic [AW-1:0] pend_addr = '0;
  int            pend_cnt = 0;
  bit            inject = 1'b0;

  initial for (int i = 0; i < 64; i++) mem_array[i] = init_line(AW'(i << 6));

  always @(posedge clk) begin
    mem_fill         <= 1'b0;
    mem_fill_data    <= '0;
    mem_fill_address <= '0;
    if (pend_cnt == 1) begin
      mem_fill         <= 1'b1;
      mem_fill_address <= pend_addr;
      mem_fill_data    <= mem_array[pend_addr[11:6]];
    end
    if (inject) begin
      mem_fill         <= 1'b1;
      mem_fill_address <= 32'h0000_0DC0;
      mem_fill_data    <= '1;
    end
    if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
    if (mem_req) begin
      if (mem_req_store) begin
        mem_array[mem_req_address[11:6]] <= mem_req_evict_data;
      end else begin
        pend_addr <= mem_req_address;
        pend_cnt  <= LAT - 1;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } fill_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic          store;
    logic [LW-1:0] data;
  } req_t;

  fill_t ic_q[$];
  fill_t dc_q[$];
  req_t  mr_q[$];
  logic [LW-1:0] ref_mem [64];
  bit            ref_last_d = 1'b0;   // last granted client, 1 = D-cache

  initial for (int i = 0; i < 64; i++) ref_mem[i] = init_line(AW'(i << 6));

  // One granted transaction whose mem_req pulse appears in cycle req_cyc.
  task automatic expect_txn(input bit is_d, input bit st, input logic [AW-1:0] a,
                            input logic [LW-1:0] d, input int req_cyc);
    req_t  rq;
    fill_t f;
    rq.cyc = req_cyc; rq.addr = a; rq.store = st; rq.data = d;
    mr_q.push_back(rq);
    f.addr = a;
    if (st) begin
      ref_mem[a[11:6]] = d;
      f.cyc  = req_cyc + SLAT;
      f.data = '0;
    end else begin
      f.cyc  = req_cyc + LAT;
      f.data = ref_mem[a[11:6]];
    end
    if (is_d) dc_q.push_back(f);
    else      ic_q.push_back(f);
    ref_last_d = is_d;
  endtask

  // ---------------- monitor ----------------
  bit    prev_req = 1'b0;
  fill_t mf;
  req_t  mq;

  always @(negedge clk) begin
    if (icache_fill) begin
      if (ic_q.size() == 0) begin
        chk(1'b0, "icache_fill_unexpected",
            $sformatf("got fill addr %h at cycle %0d, required none", icache_fill_addr, cyc));
      end else begin
        mf = ic_q.pop_front();
        chk(icache_fill_addr == mf.addr && icache_fill_data == mf.data && cyc == mf.cyc && !dcache_fill,
            "icache_fill",
            $sformatf("got addr %h data %h cyc %0d dfill %b, required addr %h data %h cyc %0d dfill 0",
                      icache_fill_addr, icache_fill_data, cyc, dcache_fill, mf.addr, mf.data, mf.cyc));
      end
    end
    if (dcache_fill) begin
      if (dc_q.size() == 0) begin
        chk(1'b0, "dcache_fill_unexpected",
            $sformatf("got fill addr %h at cycle %0d, required none", dcache_fill_addr, cyc));
      end else begin
        mf = dc_q.pop_front();
        chk(dcache_fill_addr == mf.addr && dcache_fill_data == mf.data && cyc == mf.cyc && !icache_fill,
            "dcache_fill",
            $sformatf("got addr %h data %h cyc %0d ifill %b, required addr %h data %h cyc %0d ifill 0",
                      dcache_fill_addr, dcache_fill_data, cyc, icache_fill, mf.addr, mf.data, mf.cyc));
      end
    end
    chk((icache_fill || (icache_fill_data == '0 && icache_fill_addr == '0)) &&
        (dcache_fill || (dcache_fill_data == '0 && dcache_fill_addr == '0)),
        "idle_fill_outputs_zero",
        $sformatf("got idata %h iaddr %h ddata %h daddr %h, required 0 when no pulse",
                  icache_fill_data, icache_fill_addr, dcache_fill_data, dcache_fill_addr));
    if (mem_req) begin
      if (mr_q.size() == 0) begin
        chk(1'b0, "mem_req_unexpected",
            $sformatf("got mem_req addr %h at cycle %0d, required none", mem_req_address, cyc));
      end else begin
        mq = mr_q.pop_front();
        chk(!prev_req && cyc == mq.cyc && mem_req_address == mq.addr && mem_req_store == mq.store &&
            (!mq.store || mem_req_evict_data == mq.data),
            "mem_req",
            $sformatf("got cyc %0d addr %h st %b data %h prev %b, required cyc %0d addr %h st %b data %h prev 0",
                      cyc, mem_req_address, mem_req_store, mem_req_evict_data, prev_req,
                      mq.cyc, mq.addr, mq.store, mq.data));
      end
    end
    prev_req = mem_req;
  end

  // ---------------- stimulus ----------------
  // Advance one cycle; a client drops its request in the cycle after its fill.
  task automatic step();
    bit ic_seen, dc_seen;
    @(negedge clk);
    ic_seen = icache_fill;
    dc_seen = dcache_fill;
    @(posedge clk);
    #1;
    if (ic_seen) icache_req = 1'b0;
    if (dc_seen) dcache_req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Both requests are presented in cycle r; the winner's mem_req is at r+1,
  // the loser's at r+8 (winner done, one IDLE cycle, then its grant).
  task automatic round(input bit use_i, input bit use_d, input bit d_st,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da, input logic [LW-1:0] dd);
    int r;
    bit d_first;
    r = cyc;
    if (use_i) begin icache_req = 1'b1; icache_addr = ia; end
    if (use_d) begin
      dcache_req = 1'b1; dcache_req_store = d_st; dcache_addr = da;
      dcache_evict_data = d_st ? dd : '0;
    end
    if (use_i && use_d) begin
`ifdef MEM_ARB_RR_EN
      d_first = !ref_last_d;
`else
      d_first = 1'b1;
`endif
      if (d_first) begin
        expect_txn(1'b1, d_st, da, dd, r + 1);
        expect_txn(1'b0, 1'b0, ia, '0, r + 8);
      end else begin
        expect_txn(1'b0, 1'b0, ia, '0, r + 1);
        expect_txn(1'b1, d_st, da, dd, r + 8);
      end
    end else if (use_d) begin
      expect_txn(1'b1, d_st, da, dd, r + 1);
    end else if (use_i) begin
      expect_txn(1'b0, 1'b0, ia, '0, r + 1);
    end
    wait_until(r + 16);
  endtask

  // Back-to-back I-cache reads: the second is presented as soon as the first
  // fill has been seen, so the mem_req pulses land 7 cycles apart.
  task automatic b2b(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int r;
    r = cyc;
    icache_req = 1'b1; icache_addr = a0;
    expect_txn(1'b0, 1'b0, a0, '0, r + 1);
    wait_until(r + 7);
    icache_req = 1'b1; icache_addr = a1;
    expect_txn(1'b0, 1'b0, a1, '0, r + 8);
    wait_until(r + 22);
  endtask

  // Reset three cycles into a load; memory's fill still arrives and must be dropped.
  task automatic reset_mid_load(input logic [AW-1:0] a);
    int r;
    req_t rq;
    r = cyc;
    icache_req = 1'b1; icache_addr = a;
    rq.cyc = r + 1; rq.addr = a; rq.store = 1'b0; rq.data = '0;
    mr_q.push_back(rq);
    wait_until(r + 3);
    reset = 1'b1;
    icache_req = 1'b0;
    #1;
    chk(!mem_req && !mem_req_store && mem_req_address == '0 && mem_req_evict_data == '0 &&
        !icache_fill && !dcache_fill,
        "reset_mid_load_outputs",
        $sformatf("got req %b st %b addr %h ifill %b dfill %b, required all 0",
                  mem_req, mem_req_store, mem_req_address, icache_fill, dcache_fill));
    step();
    reset = 1'b0;
    ref_last_d = 1'b0;
    wait_until(r + 12);
  endtask

  task automatic stray_fill();
    int r;
    r = cyc;
    inject = 1'b1;
    step();
    inject = 1'b0;
    wait_until(r + 4);
  endtask

  initial begin
    #2;
    chk(!mem_req && !mem_req_store && mem_req_address == '0 && mem_req_evict_data == '0 &&
        !icache_fill && !dcache_fill && icache_fill_data == '0 && dcache_fill_data == '0,
        "reset_state",
        $sformatf("got req %b st %b addr %h ifill %b dfill %b, required all 0",
                  mem_req, mem_req_store, mem_req_address, icache_fill, dcache_fill));
    step(); step();
    reset = 1'b0;
    step();

    round(1'b1, 1'b0, 1'b0, 32'h100, '0, '0);
    round(1'b0, 1'b1, 1'b1, '0, 32'h200, {16{8'hA5}});
    round(1'b0, 1'b1, 1'b0, '0, 32'h200, '0);
    round(1'b1, 1'b1, 1'b0, 32'h100, 32'h240, '0);
    round(1'b1, 1'b1, 1'b0, 32'h180, 32'h280, '0);
    reset_mid_load(32'h100);
    b2b(32'h100, 32'h140);
    stray_fill();
    round(1'b1, 1'b1, 1'b1, 32'h200, 32'h200, {4{32'h1234_5678}});

    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] dd;
      kind = $urandom_range(0, 5);
      ia = AW'($urandom_range(0, 63) << 6);
      da = AW'($urandom_range(0, 63) << 6);
      dd = {$urandom, $urandom, $urandom, $urandom};
      case (kind)
        0: round(1'b1, 1'b0, 1'b0, ia, da, dd);
        1: round(1'b0, 1'b1, 1'b0, ia, da, dd);
        2: round(1'b0, 1'b1, 1'b1, ia, da, dd);
        3: round(1'b1, 1'b1, 1'($urandom_range(0, 1)), ia, da, dd);
        4: stray_fill();
        default: b2b(ia, da);
      endcase
    end

    wait_until(cyc + 4);
    chk(ic_q.size() == 0, "icache_fills_outstanding",
        $sformatf("got %0d pending, required 0", ic_q.size()));
    chk(dc_q.size() == 0, "dcache_fills_outstanding",
        $sformatf("got %0d pending, required 0", dc_q.size()));
    chk(mr_q.size() == 0, "mem_req_outstanding",
        $sformatf("got %0d pending, required 0", mr_q.size()));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
